// File: rtl/jt053244_pkg.sv
// Shared types and constants for the jt053244 object-table DMA.
package jt053244_pkg;
    typedef enum logic [2:0] {IDLE, RD, CHK, COPY, FILL, DONE} state_t;
    localparam int ENABLE_BIT = 15;
    localparam int SUBW       = 2;
endpackage

// File: rtl/jt053244_dma_arb.sv
// Object RAM port sharing (CPU first) and the one-deep read return register.
module jt053244_dma_arb
    import jt053244_pkg::*;
#(
    parameter int OBJW = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cen,
    input  logic                 cpu_cs,
    input  logic                 cpu_we,
    input  logic [OBJW+SUBW-1:0] cpu_addr,
    input  logic                 dma_rd,
    input  logic [OBJW+SUBW-1:0] dma_addr,
    input  logic                 consume,
    input  logic [31:0]          src_dout,
    output logic [OBJW+SUBW-1:0] src_addr,
    output logic                 src_we,
    output logic                 issue,
    output logic                 rd_valid,
    output logic [31:0]          rd_data
);
    logic        rd_pend;
    logic        hold_v;
    logic [31:0] hold;

    assign src_addr = cpu_cs ? cpu_addr : dma_addr;
    assign src_we   = cpu_cs & cpu_we;
    assign issue    = dma_rd & ~cpu_cs;

    // Returning data is usable in its arrival cycle; hold only keeps it if not consumed then.
    assign rd_valid = rd_pend | hold_v;
    assign rd_data  = rd_pend ? src_dout : hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0;
            hold_v  <= 1'b0;
            hold    <= '0;
        end else if (cen) begin
            rd_pend <= issue;
            if (rd_pend) begin
                hold   <= src_dout;
                hold_v <= ~consume;
            end else if (consume) begin
                hold_v <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/jt053244_dma.sv
// Copies enabled objects from object RAM into the scan buffer on vblank, clearing unused slots.
module jt053244_dma
    import jt053244_pkg::*;
#(
    parameter int OBJW = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic            vs,
    input  logic            dma_trig,
    input  logic            cpu_cs,
    input  logic            cpu_we,
    input  logic [OBJW+1:0] cpu_addr,
    output logic [OBJW+1:0] src_addr,
    output logic            src_we,
    input  logic [31:0]     src_dout,
    output logic [OBJW+1:0] dst_addr,
    output logic            dst_we,
    output logic [31:0]     dst_din,
    output logic            busy,
    output logic            dma_done,
    output logic [OBJW:0]   obj_cnt,
    output state_t          fsm_state
);
    state_t            state, state_nxt;
    logic [OBJW-1:0]   src_obj, src_nxt;
    logic [OBJW-1:0]   dst_obj, dst_nxt;
    logic [SUBW-1:0]   sub, sub_nxt;
    logic              iss, iss_nxt;
    logic [OBJW:0]     cnt_tmp, tmp_nxt, cnt_nxt;
    logic              busy_nxt, done_nxt, we_nxt;
    logic [OBJW+1:0]   waddr_nxt;
    logic [31:0]       wdata_nxt;
    logic              armed, armed_nxt, vs_l;
    logic              dma_rd, consume, issue, rd_valid, start;
    logic [OBJW+1:0]   dma_addr;
    logic [31:0]       rd_data;

    assign fsm_state = state;
    assign start     = vs & ~vs_l & (armed | dma_trig) & (state == IDLE);

    jt053244_dma_arb #(.OBJW(OBJW)) u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .cen      (cen),
        .cpu_cs   (cpu_cs),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .dma_rd   (dma_rd),
        .dma_addr (dma_addr),
        .consume  (consume),
        .src_dout (src_dout),
        .src_addr (src_addr),
        .src_we   (src_we),
        .issue    (issue),
        .rd_valid (rd_valid),
        .rd_data  (rd_data)
    );

    always_comb begin
        state_nxt = state;
        src_nxt   = src_obj;
        dst_nxt   = dst_obj;
        sub_nxt   = sub;
        iss_nxt   = iss;
        tmp_nxt   = cnt_tmp;
        cnt_nxt   = obj_cnt;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        we_nxt    = 1'b0;
        waddr_nxt = dst_addr;
        wdata_nxt = dst_din;
        armed_nxt = armed | dma_trig;
        dma_rd    = 1'b0;
        dma_addr  = {src_obj, sub};
        consume   = 1'b0;
        case (state)
            IDLE: if (start) begin
                armed_nxt = 1'b0;
                state_nxt = RD;
                src_nxt   = '0;
                dst_nxt   = '0;
                tmp_nxt   = '0;
                busy_nxt  = 1'b1;
            end
            RD: begin
                dma_rd   = 1'b1;
                dma_addr = {src_obj, SUBW'(0)};
                if (issue) state_nxt = CHK;
            end
            CHK: if (rd_valid) begin
                consume = 1'b1;
                if (rd_data[ENABLE_BIT]) begin
                    we_nxt    = 1'b1;
                    waddr_nxt = {dst_obj, SUBW'(0)};
                    wdata_nxt = rd_data;
                    dma_rd    = 1'b1;
                    dma_addr  = {src_obj, SUBW'(1)};
                    iss_nxt   = issue;
                    sub_nxt   = SUBW'(1);
                    state_nxt = COPY;
                end else begin
                    src_nxt   = src_obj + OBJW'(1);
                    state_nxt = (&src_obj) ? FILL : RD;
                end
            end
            COPY: if (!iss) begin
                // read for this sub-word was blocked by the CPU; retry it
                dma_rd   = 1'b1;
                dma_addr = {src_obj, sub};
                iss_nxt  = issue;
            end else if (rd_valid) begin
                consume   = 1'b1;
                we_nxt    = 1'b1;
                waddr_nxt = {dst_obj, sub};
                wdata_nxt = rd_data;
                if (sub != SUBW'(3)) begin
                    sub_nxt  = sub + SUBW'(1);
                    dma_rd   = 1'b1;
                    dma_addr = {src_obj, sub + SUBW'(1)};
                    iss_nxt  = issue;
                end else begin
                    src_nxt = src_obj + OBJW'(1);
                    dst_nxt = dst_obj + OBJW'(1);
                    tmp_nxt = cnt_tmp + (OBJW+1)'(1);
                    if (!(&src_obj))     state_nxt = RD;
                    else if (&dst_obj)   state_nxt = DONE;
                    else                 state_nxt = FILL;
                end
            end
            FILL: begin
                we_nxt    = 1'b1;
                waddr_nxt = {dst_obj, SUBW'(0)};
                wdata_nxt = 32'h0;
                dst_nxt   = dst_obj + OBJW'(1);
                if (&dst_obj) state_nxt = DONE;
            end
            DONE: begin
                busy_nxt  = 1'b0;
                done_nxt  = 1'b1;
                cnt_nxt   = cnt_tmp;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_obj  <= '0;
            dst_obj  <= '0;
            sub      <= '0;
            iss      <= 1'b0;
            cnt_tmp  <= '0;
            obj_cnt  <= '0;
            busy     <= 1'b0;
            dma_done <= 1'b0;
            dst_we   <= 1'b0;
            dst_addr <= '0;
            dst_din  <= '0;
            armed    <= 1'b0;
            vs_l     <= 1'b0;
        end else if (cen) begin
            state    <= state_nxt;
            src_obj  <= src_nxt;
            dst_obj  <= dst_nxt;
            sub      <= sub_nxt;
            iss      <= iss_nxt;
            cnt_tmp  <= tmp_nxt;
            obj_cnt  <= cnt_nxt;
            busy     <= busy_nxt;
            dma_done <= done_nxt;
            dst_we   <= we_nxt;
            dst_addr <= waddr_nxt;
            dst_din  <= wdata_nxt;
            armed    <= armed_nxt;
            vs_l     <= vs;
        end
    end
endmodule

// File: doc/jt053244_dma.md
Name: jt053244_dma

Overview:
- Object-table DMA controller feeding the sprite scan engine's buffer.
- On the first vertical-blank edge after a CPU trigger, copies the CPU object RAM into the scan buffer and compacts it: only objects with the enable bit (even word bit 15) set are copied, and the unused tail slots are cleared.
- Shares the object RAM read port with the CPU; the CPU always has priority.
- Sits between the CPU bus decoder / object RAM and the scan buffer read by the table-scan block.

Parameters:
OBJW, 7, log2 of object count; the table holds 2^OBJW objects of 4 x 32-bit sub-words.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cen  in  1  clock enable; all state advances only when cen=1
vs  in  1  vertical sync, active high; the rising edge starts an armed transfer
dma_trig  in  1  one-cen pulse from a CPU register write; arms the transfer
cpu_cs  in  1  CPU accesses object RAM this cen cycle
cpu_we  in  1  CPU write strobe
cpu_addr  in  OBJW+2  CPU 32-bit word address
src_addr  out  OBJW+2  object RAM address (muxed CPU/DMA)
src_we  out  1  object RAM write enable (= cpu_cs & cpu_we)
src_dout  in  32  object RAM read data; {odd, even}, 1 cen cycle latency
dst_addr  out  OBJW+2  scan buffer write address {dst_obj, sub}
dst_we  out  1  scan buffer write strobe
dst_din  out  32  scan buffer write data
busy  out  1  transfer in progress
dma_done  out  1  one-cen pulse when a transfer ends
obj_cnt  out  OBJW+1  number of enabled objects copied by the last transfer

Behaviour:
- Reset, all registered outputs: busy=0, dma_done=0, dst_we=0, obj_cnt=0, dst_addr=0, dst_din=0. armed=0, state=IDLE. Reset mid-transfer aborts it with no completion pulse.
- Arming:
  - armed is set on dma_trig; cleared when a transfer starts.
  - A trigger during busy re-arms for the next frame.
  - Trigger and vs rising in the same cen cycle: the transfer starts and armed is left clear.
- Start: vs rising edge (registered vs_l) while armed and IDLE → state RD, src_obj=0, dst_obj=0, busy=1. A vs edge while busy is ignored.
- Port mux: cpu_cs=1 → src_addr=cpu_addr and the DMA issues nothing that cycle. Otherwise src_addr is driven by the DMA.
- Read pipeline:
  - A DMA read issued in cen cycle t sets rd_pend.
  - At t+1, src_dout is captured into hold and hold_v=1, regardless of cpu_cs.
  - The FSM consumes hold; hold_v is cleared on consumption.
- FSM:
  - IDLE: wait for the start condition.
  - RD: if !cpu_cs, issue {src_obj,2'd0} → CHK.
  - CHK: wait for hold_v.
    - hold[15]=1: dst_we=1, dst_addr={dst_obj,0}, dst_din=hold. Issue {src_obj,1} when !cpu_cs (else wait in COPY with pending issue), sub=1 → COPY.
    - hold[15]=0: src_obj++ → RD, or FILL if src_obj was last.
  - COPY(sub):
    - Each sub-word needs its issue done and hold_v; then write {dst_obj,sub} and issue sub+1 if sub<3.
    - After sub 3 is written: dst_obj++, src_obj++, obj_cnt_tmp++; next state is RD, or FILL on the last object.
  - FILL: while dst_obj ≤ max, write {dst_obj,0}=32'h0 once per cen cycle and increment dst_obj. After the maximum index → DONE.
  - DONE: busy=0, dma_done=1 for one cen cycle, obj_cnt=obj_cnt_tmp → IDLE.
- Timing without CPU contention: disabled object = 2 cen cycles, enabled object = 5, fill slot = 1, DONE = 1.
- Boundary: all objects enabled → FILL writes nothing. None enabled → all slots are filled and obj_cnt=0.
- Wrap: counters are OBJW+1 bits wide; obj_cnt reaches exactly 2^OBJW and never wraps.
- dst_we is a single-cycle strobe, never asserted while in IDLE.

Decomposition:
- Shared package jt053244_pkg: state enum (IDLE, RD, CHK, COPY, FILL, DONE), ENABLE_BIT=15, SUBW=2.
- One natural sub-module, jt053244_dma_arb: the CPU/DMA address mux plus the rd_pend/hold capture register.
- The FSM stays in the top module.

Test Plan:
- Objects 0, 5, 127 enabled; trig, then vs rise → buffer slots 0, 1, 2 = objects 0, 5, 127 (all 4 sub-words); slots 3..127 word0=0; obj_cnt=3; dma_done pulse; busy for 2·125+5·3+125+1 cen cycles.
- No trig, vs rises → no dst_we, busy stays 0.
- cpu_cs held high for 10 cycles mid-COPY of object 5 → transfer stalls; copied data still matches source; src_we follows cpu_we only.
- Trig during busy → second transfer starts on the next vs rise. Trig coinciding with vs rise from IDLE → exactly one transfer.
- All 128 objects enabled → obj_cnt=128, no FILL writes, 641 busy cycles.
- rst_n low mid-COPY → busy=0 immediately, no dma_done; next trig plus vs gives a full, correct transfer.
